// File: rtl/pipe_shifter.sv
// Elastic, pipelined barrel shifter (SLL/SRL/SRA) with valid/ready at both ends, flush and tag.
// Optional rotate-right on op 2'b11 when SHIFTER_ROTATE_EN is defined; otherwise op 2'b11 is SLL.
module pipe_shifter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 5,
  localparam int unsigned SHW        = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned LvlBase  = SHW / PIPE_STAGES;
  localparam int unsigned LvlExtra = SHW % PIPE_STAGES;

  // Earlier stages take the leftover mux levels.
  function automatic int unsigned lvl_lo(input int unsigned k);
    return k * LvlBase + ((k < LvlExtra) ? k : LvlExtra);
  endfunction

  function automatic int unsigned lvl_cnt(input int unsigned k);
    return LvlBase + ((k < LvlExtra) ? 1 : 0);
  endfunction

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int unsigned      sh,
                                                   input logic [1:0]       op);
    logic signed [WIDTH-1:0] s;
    logic        [WIDTH-1:0] r;
    s = d;
    case (op)
      2'b01:   r = d >> sh;
      2'b10:   r = s >>> sh;
`ifdef SHIFTER_ROTATE_EN
      2'b11:   r = (d >> sh) | (d << (WIDTH - sh));
`endif
      default: r = d << sh;
    endcase
    return r;
  endfunction

  logic [PIPE_STAGES-1:0] r_valid;
  logic [WIDTH-1:0]       r_data  [PIPE_STAGES];
  logic [SHW-1:0]         r_shamt [PIPE_STAGES];
  logic [1:0]             r_op    [PIPE_STAGES];
  logic [TAG_W-1:0]       r_tag   [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] w_in_valid;
  logic [PIPE_STAGES-1:0] w_ready;
  logic [PIPE_STAGES-1:0] w_load;
  logic [WIDTH-1:0]       w_in_data  [PIPE_STAGES];
  logic [SHW-1:0]         w_in_shamt [PIPE_STAGES];
  logic [1:0]             w_in_op    [PIPE_STAGES];
  logic [TAG_W-1:0]       w_in_tag   [PIPE_STAGES];
  logic [WIDTH-1:0]       w_nxt_data [PIPE_STAGES];

  always_comb begin
    w_in_valid[0] = valid_i;
    w_in_data[0]  = data_i;
    w_in_shamt[0] = shamt_i;
    w_in_op[0]    = op_i;
    w_in_tag[0]   = tag_i;
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_data[k]  = r_data[k-1];
      w_in_shamt[k] = r_shamt[k-1];
      w_in_op[k]    = r_op[k-1];
      w_in_tag[k]   = r_tag[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] w_d;
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      w_d = w_in_data[k];
      for (int unsigned l = 0; l < SHW; l++) begin
        if (l >= lvl_lo(k) && l < lvl_lo(k) + lvl_cnt(k) && w_in_shamt[k][l]) begin
          w_d = shift_level(w_d, 32'd1 << l, w_in_op[k]);
        end
      end
      w_nxt_data[k] = w_d;
    end
  end

  // A stage can take new content if it or any later stage has a bubble, or the sink accepts.
  always_comb begin
    logic w_any_empty;
    w_any_empty = 1'b0;
    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
      w_any_empty                  = w_any_empty | ~r_valid[PIPE_STAGES-1-i];
      w_ready[PIPE_STAGES-1-i]     = ready_i | w_any_empty;
    end
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      w_load[k] = w_ready[k] & w_in_valid[k] & ~flush_i;
    end
  end

  assign ready_o = w_ready[0] & ~flush_i;
  assign valid_o = r_valid[PIPE_STAGES-1];
  assign data_o  = r_data[PIPE_STAGES-1];
  assign tag_o   = r_tag[PIPE_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_op[k]    <= '0;
        r_tag[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        if (flush_i) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_in_valid[k];
        end
        // Payload only moves with a real transfer so idle stages stay quiet.
        if (w_load[k]) begin
          r_data[k]  <= w_nxt_data[k];
          r_shamt[k] <= w_in_shamt[k];
          r_op[k]    <= w_in_op[k];
          r_tag[k]   <= w_in_tag[k];
        end
      end
    end
  end

endmodule
